// File: rtl/dmem_responder_if.sv
// Request/response bus between the memory-access stage and the data memory.
// The requester drives the master side; the responder sits on the slave side.
interface dmem_responder_if;
    logic        re;
    logic [2:0]  re_type_sel;
    logic        we;
    logic [2:0]  we_type_sel;
    logic [63:0] data_addr_i;
    logic [7:0]  wmask_i;
    logic [63:0] wdata_i;
    logic [63:0] rdata_o;
    logic        mem_finish;
    logic        access_fault;

    modport master (
        output re, re_type_sel, we, we_type_sel,
        output data_addr_i, wmask_i, wdata_i,
        input  rdata_o, mem_finish, access_fault
    );

    modport slave (
        input  re, re_type_sel, we, we_type_sel,
        input  data_addr_i, wmask_i, wdata_i,
        output rdata_o, mem_finish, access_fault
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-side memory responder: one access at a time, fixed wait,
// byte-maskable 64-bit array, one-cycle completion pulse.
module dmem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2,
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);
    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_store;
    logic [2:0]  r_type;
    logic [63:0] r_addr;
    logic [7:0]  r_wmask;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;
    logic        r_fault;
    logic [63:0] r_mem [DEPTH];

    logic                  w_idle;
    logic                  w_req;
    logic                  w_accept;
    logic                  w_commit;
    logic                  w_store;
    logic [2:0]            w_type;
    logic [63:0]           w_addr;
    logic [7:0]            w_wmask;
    logic [63:0]           w_wdata;
    logic [63:0]           w_off;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_range_bad;
    logic                  w_type_ok;
    logic                  w_align_ok;
    logic                  w_fault;

    assign w_idle   = (r_state == S_IDLE);
    assign w_req    = bus.re | bus.we;
    assign w_accept = w_idle & w_req;

    // With zero wait the access commits on the accepting edge itself,
    // so operands come straight from the bus instead of the latches.
    assign w_commit = (w_accept & (LAT == 4'd0))
                    | ((r_state == S_WAIT) & (r_cnt <= 4'd1));

    assign w_store = w_idle ? bus.we : r_store;
    assign w_type  = w_idle ? (bus.we ? bus.we_type_sel : bus.re_type_sel)
                            : r_type;
    assign w_addr  = w_idle ? bus.data_addr_i : r_addr;
    assign w_wmask = w_idle ? bus.wmask_i : r_wmask;
    assign w_wdata = w_idle ? bus.wdata_i : r_wdata;

    assign w_off       = w_addr - BASE_ADDR;
    assign w_idx       = DEPTH_LOG2'(w_off >> 3);
    assign w_range_bad = (w_addr < BASE_ADDR) | (w_off >= SPAN);

    always_comb begin
        w_type_ok  = 1'b1;
        w_align_ok = 1'b1;
        case (w_type)
            3'b000: w_align_ok = 1'b1;
            3'b001: w_align_ok = ~w_addr[0];
            3'b010: w_align_ok = (w_addr[1:0] == 2'b00);
            3'b100: w_align_ok = (w_addr[2:0] == 3'b000);
            default: w_type_ok = 1'b0;
        endcase
    end

    assign w_fault = w_range_bad | ~w_type_ok | ~w_align_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) w_next = (LAT == 4'd0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) w_next = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Array has no reset; an access abandoned by reset never reaches it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_store <= 1'b0;
            r_type  <= '0;
            r_addr  <= '0;
            r_wmask <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_fault <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= LAT;
                r_store <= bus.we;
                r_type  <= w_type;
                r_addr  <= bus.data_addr_i;
                r_wmask <= bus.wmask_i;
                r_wdata <= bus.wdata_i;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_fault <= w_fault;
                if (!w_fault && !w_store) r_rdata <= r_mem[w_idx];
                if (!w_fault && w_store) begin
                    for (int i = 0; i < 8; i++) begin
                        if (w_wmask[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    assign bus.rdata_o      = r_rdata;
    assign bus.mem_finish   = (r_state == S_RESP);
    assign bus.access_fault = (r_state == S_RESP) & r_fault;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side memory responder for the load/store stage: accepts one load or store request at a time from the memory-access stage, services it against an internal 64-bit-wide byte-maskable array after a programmable wait, and returns read data plus a one-cycle `mem_finish` completion pulse. It is the far end of the stage's `re`/`we`/type-select/address/mask/data request interface. The stage's scoreboard stall is released by that pulse.

## Interface

Parameters:
- `DEPTH_LOG2`, default 10: array depth, 2^DEPTH_LOG2 doublewords (8 KiB at default).
- `LATENCY`, default 2: wait cycles inserted between accept and completion; legal range 0..15.
- `BASE_ADDR`, default 64'h0000_0000_8000_0000: byte address of doubleword 0.

Ports:
- `clk`  in  1  clock; all state on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `re`  in  1  load request.
- `re_type_sel`  in  3  000 byte, 001 half, 010 word, 100 double, 111 none.
- `we`  in  1  store request.
- `we_type_sel`  in  3  same encoding as `re_type_sel`.
- `data_addr_i`  in  64  byte address.
- `wmask_i`  in  8  store byte-lane enables, bit n = bits [8n+7:8n].
- `wdata_i`  in  64  store data, already lane-aligned.
- `rdata_o`  out  64  full aligned doubleword for loads; the requester extracts and extends lanes.
- `mem_finish`  out  1  one-cycle completion pulse.
- `access_fault`  out  1  qualifies `mem_finish`; the access was rejected.

## Operation

- The FSM has three states: IDLE, WAIT, RESP.
- IDLE, when `re|we` is high: accept the request. Latch address, type, mask, wdata and direction. Load the wait counter with LATENCY. Go to WAIT, or directly to RESP if LATENCY=0.
- WAIT: decrement the counter each cycle. When the counter reaches 1, the array access happens on the edge into RESP.
- RESP: `mem_finish`=1 for exactly this cycle, then return to IDLE unconditionally. Requests are never accepted while in RESP.
- Index = (addr − BASE_ADDR)[DEPTH_LOG2+2:3]. Address bits [2:0] select lanes only through the mask.
- Store: array[index] lanes with mask bit set take wdata lanes. All other lanes are unchanged. `wmask_i`=0 completes with no change.
- Load: `rdata_o` is registered with array[index] on entry to RESP. It holds that value until the next successful load completes. Stores and faults do not change it.
- `re` and `we` both high: treated as a store; `re` is ignored.
- Fault conditions, with no array write, `rdata_o` unchanged and `access_fault`=1 alongside `mem_finish`:
  - addr < BASE_ADDR, or addr − BASE_ADDR ≥ 8·2^DEPTH_LOG2;
  - type select 111, or any encoding other than 000/001/010/100;
  - misalignment: half requires addr[0]=0, word requires addr[1:0]=0, double requires addr[2:0]=0.
- The requester holds its request stable until it samples `mem_finish`. A request still present in the cycle after RESP is accepted as a new access. This is idempotent for loads, and for stores it rewrites the same data.
- Reset: asynchronous to IDLE. `mem_finish`=0, `access_fault`=0, `rdata_o`=0. Any in-flight access is abandoned and an uncommitted store is not written. Array contents are not reset.

## Timing

- A request is sampled in cycle T while in IDLE. `mem_finish` is high in cycle T+1+LATENCY, and `rdata_o` is valid in that same cycle.
- Throughput is one access per LATENCY+2 cycles.
- A store committed at completion is visible to a load accepted in any later cycle.
- `access_fault` is 0 whenever `mem_finish` is 0.
- Reset asserted while in WAIT: outputs clear immediately, asynchronously. The first request after reset deassertion is accepted on the first rising edge where `rst`=1.

## Test plan

- LATENCY=2. Store double 64'h1122334455667788 to BASE+0x10, mask FF, finish at T+3. Then load double from BASE+0x10 → `rdata_o`=64'h1122334455667788, `access_fault`=0.
- Byte store, addr BASE+0x13, mask 08, wdata 64'h0000_0000_AB00_0000 over that stored value. Then load → 64'h11223344AB667788.
- Load half at BASE+0x11 → `mem_finish` with `access_fault`=1 and `rdata_o` unchanged. Load double at BASE+0x2000 (DEPTH_LOG2=10) → fault.
- `re`=`we`=1, type 100, mask 0F, wdata 64'hFFFF_FFFF_FFFF_FFFF at BASE+0x10 → treated as a store; a later load returns 64'h11223344FFFFFFFF.
- Assert `rst` in the WAIT cycle of a store of 64'hDEAD at BASE+0x18 (previously 0) → outputs 0 immediately, no `mem_finish`. A load after reset returns 0.
- LATENCY=0 with back-to-back held loads → `mem_finish` pulses every 2 cycles, never in consecutive cycles.
